sample_frame_fifo: RTL and testbench
====================================

# sample_frame_fifo

Parametrised multi-channel sample FIFO between `data_buffer` and the UART/wifi transmitter. It replaces the fixed two-LED, 22-bit `fifov1`. Each `new_samples` pulse captures one frame of NUM_CH channels, tags it with a wrapping sequence number, and stores it in a DEPTH-frame circular buffer. Frames leave through a first-word-fall-through valid/ready port, with a selectable overflow policy and a saturating drop counter.

## Interface
- DATA_W, 22, bits per channel sample
- NUM_CH, 2, channels per frame (LED1, LED2, ambient…)
- DEPTH, 16, frames stored; power of two, ≥2
- DROP_OLDEST, 0, full policy: 0 = discard incoming, 1 = overwrite oldest
- SEQ_W, 8, sequence tag width
- clk  in  1  system clock
- reset_n  in  1  one clock; reset is asynchronous and active-low
- clear  in  1  synchronous flush
- new_samples  in  1  one-cycle frame strobe
- samples_in  in  NUM_CH*DATA_W  channel 0 in LSBs
- frame_valid  out  1  head frame available
- frame_data  out  NUM_CH*DATA_W  head frame samples
- frame_seq  out  SEQ_W  head frame sequence tag
- frame_ready  in  1  consumer accepts head
- level  out  $clog2(DEPTH)+1  frames stored
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- drop_cnt  out  16  frames lost; saturates at 0xFFFF

## Operation
- **Write:** a write occurs on a `new_samples` cycle.
  - Stores `samples_in` and the current `wr_seq` at `wr_ptr`.
  - `wr_ptr` increments mod DEPTH.
  - `wr_seq` increments on every strobe, including dropped ones, so the consumer sees gaps.
- **Read:** a read occurs when `frame_valid && frame_ready`; `rd_ptr` increments mod DEPTH.
- **Occupancy states** (derived from `level`):
  - EMPTY: level = 0.
  - PARTIAL.
  - FULL: level = DEPTH.
  - Transitions are driven only by write, read and clear.
- **Write while FULL, no read:**
  - DROP_OLDEST=0: frame discarded, pointers unchanged, `drop_cnt`+1.
  - DROP_OLDEST=1: frame written, `rd_ptr`+1, `level` stays DEPTH, `drop_cnt`+1.
- **Write and read, same cycle, FULL:** both succeed, no drop, `level` unchanged.
- **Write and read, same cycle, EMPTY:** `frame_valid` is 0, so there is no read; the write is accepted and `level` becomes 1.
- **Write and read, PARTIAL:** `level` unchanged.
- **Clear:**
  - Effect: pointers, `level`, `drop_cnt` and `wr_seq` go to 0.
  - A `new_samples` in the same cycle is discarded and not counted; clear wins over everything.
- **`frame_data`/`frame_seq` stability:**
  - Stable while `frame_valid && !frame_ready`, except DROP_OLDEST=1 at FULL with a write, where the head advances.
  - The consumer simply takes whatever head is presented.
- **Arithmetic:**
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - `level` is the exact count, updated by +1/−1/0.
  - `drop_cnt` does not wrap.

## Timing
- **Reset values:**
  - `frame_valid` 0, `frame_data` 0, `frame_seq` 0, `level` 0, `full` 0, `empty` 1, `drop_cnt` 0.
  - Internal pointers and `wr_seq` 0.
- **Write latency:** a frame written at edge N into an empty FIFO gives `frame_valid`=1 and a valid head after edge N (visible in cycle N+1).
- **Read latency:** after an accepted read at edge N, the next head appears in cycle N+1. Back-to-back reads at one frame per cycle are supported.
- **Status outputs:** `level`, `full`, `empty` and `drop_cnt` are registered and reflect edge N in cycle N+1.
- **Reset mid-operation:** reset asserted asynchronously forces all of the above immediately. The first write after deassertion gets seq 0.

## Structure
- Package `pulseox_pkg`:
  - default DATA_W/NUM_CH constants;
  - a function returning channel k's slice from a packed frame;
  - `DROP_NEWEST`/`DROP_OLDEST` policy constants.
- Sub-module `frame_ram`:
  - simple dual-port array, DEPTH × (NUM_CH*DATA_W+SEQ_W);
  - synchronous write, asynchronous read at `rd_ptr`;
  - infers distributed RAM.
- The top holds the pointers, level, sequence and drop-counter logic.

## Test plan
- **Basic order:** Reset, then 3 strobes with frames {1,2},{3,4},{5,5}, `frame_ready`=0 → `level`=3, head {1,2} seq 0. Raise `frame_ready` → frames are read out in order with seq 0,1,2, then `empty`=1.
- **Overflow, discard incoming:** DROP_OLDEST=0, DEPTH=4, 6 strobes with no reads → `full`=1, `drop_cnt`=2, heads read out with seq 0,1,2,3.
- **Overflow, overwrite oldest:** DROP_OLDEST=1, DEPTH=4, 6 strobes with no reads → `drop_cnt`=2, heads read out with seq 2,3,4,5.
- **Simultaneous events:**
  - at FULL, strobe with `frame_ready`=1 → `level` stays 4, `drop_cnt` unchanged;
  - at EMPTY, strobe with `frame_ready`=1 → `level`=1.
- **Clear and reset:**
  - `clear` with `new_samples` in the same cycle at `level`=3 → `level`=0, `drop_cnt`=0, next frame seq 0;
  - async `reset_n` pulse mid-burst → outputs return to reset values with no clock edge.
- **Saturation and wrap:** NUM_CH=4, DEPTH=8, 70000 overflow strobes → `drop_cnt`=0xFFFF, `frame_seq` wraps 255→0.

Source files
------------

// File: rtl/pulseox_pkg.sv
// Shared constants and helpers for the pulse-oximeter sample path.
package pulseox_pkg;

  localparam int DEF_DATA_W = 22;
  localparam int DEF_NUM_CH = 2;

  // Full-FIFO policy selectors
  localparam bit DROP_NEWEST = 1'b0;
  localparam bit DROP_OLDEST = 1'b1;

  localparam int MAX_FRAME_W = 256;
  localparam int MAX_DATA_W  = 32;

  // Extract channel k (channel 0 in the LSBs) from a packed frame.
  function automatic logic [MAX_DATA_W-1:0] channel_slice(
    input logic [MAX_FRAME_W-1:0] frame,
    input int                     data_w,
    input int                     k
  );
    logic [MAX_FRAME_W-1:0] shifted;
    logic [MAX_DATA_W-1:0]  mask;
    shifted = frame >> (k * data_w);
    mask    = (MAX_DATA_W'(1) << data_w) - MAX_DATA_W'(1);
    return shifted[MAX_DATA_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: synchronous write, asynchronous read.
module frame_ram #(
  parameter  int WIDTH = 52,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Combinational read gives first-word-fall-through on the head pointer.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_frame_fifo.sv
// Multi-channel sample FIFO with sequence tagging, FWFT output port,
// selectable overflow policy and a saturating drop counter.
module sample_frame_fifo #(
  parameter  int DATA_W      = pulseox_pkg::DEF_DATA_W,
  parameter  int NUM_CH      = pulseox_pkg::DEF_NUM_CH,
  parameter  int DEPTH       = 16,
  parameter  bit DROP_OLDEST = pulseox_pkg::DROP_NEWEST,
  parameter  int SEQ_W       = 8,
  localparam int FRAME_W     = NUM_CH * DATA_W,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int LVL_W       = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               new_samples,
  input  logic [FRAME_W-1:0] samples_in,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data,
  output logic [SEQ_W-1:0]   frame_seq,
  input  logic               frame_ready,
  output logic [LVL_W-1:0]   level,
  output logic               full,
  output logic               empty,
  output logic [15:0]        drop_cnt
);

  localparam bit OVERWRITE = (DROP_OLDEST == pulseox_pkg::DROP_OLDEST);

  logic [PTR_W-1:0]         wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0]         rd_ptr, rd_ptr_next;
  logic [LVL_W-1:0]         level_next;
  logic [SEQ_W-1:0]         wr_seq, wr_seq_next;
  logic [15:0]              drop_next;
  logic                     wr_en, rd_en, overflow;
  logic [SEQ_W+FRAME_W-1:0] rd_word;

  assign empty       = (level == '0);
  assign full        = (level == LVL_W'(DEPTH));
  assign frame_valid = !empty;

  assign rd_en    = frame_valid && frame_ready && !clear;
  // A strobe at FULL with no simultaneous read has nowhere to go.
  assign overflow = new_samples && !clear && full && !rd_en;
  assign wr_en    = new_samples && !clear && (!overflow || OVERWRITE);

  frame_ram #(
    .WIDTH (SEQ_W + FRAME_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({wr_seq, samples_in}),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  // RAM contents are not reset, so the head is masked while empty.
  assign frame_data = frame_valid ? rd_word[FRAME_W-1:0] : '0;
  assign frame_seq  = frame_valid ? rd_word[SEQ_W+FRAME_W-1:FRAME_W] : '0;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    level_next  = level;
    wr_seq_next = wr_seq;
    drop_next   = drop_cnt;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
      wr_seq_next = '0;
      drop_next   = '0;
    end else begin
      if (new_samples) wr_seq_next = wr_seq + SEQ_W'(1);
      if (wr_en)       wr_ptr_next = wr_ptr + PTR_W'(1);
      // Overwriting at FULL pushes the head forward past the oldest frame.
      if (rd_en || (wr_en && overflow)) rd_ptr_next = rd_ptr + PTR_W'(1);
      if (overflow && (drop_cnt != 16'hFFFF)) drop_next = drop_cnt + 16'd1;
      if (wr_en && !rd_en && !overflow)  level_next = level + LVL_W'(1);
      else if (rd_en && !wr_en)          level_next = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_seq   <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      level    <= level_next;
      wr_seq   <= wr_seq_next;
      drop_cnt <= drop_next;
    end
  end

endmodule

// File: tb/tb_sample_frame_fifo.sv
// Three FIFO configurations share one stimulus stream and are compared
// against a queue-based reference model every cycle.
module tb_sample_frame_fifo;
  import pulseox_pkg::*;

  typedef struct {
    logic [87:0] d;
    logic [7:0]  s;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0;
  logic        new_samples = 1'b0;
  logic        frame_ready = 1'b0;
  logic [87:0] samples = '0;

  logic        fv0, fv1, fv2, fu0, fu1, fu2, em0, em1, em2;
  logic [43:0] fd0, fd1;
  logic [87:0] fd2;
  logic [7:0]  fs0, fs1, fs2;
  logic [2:0]  lv0, lv1;
  logic [3:0]  lv2;
  logic [15:0] dc0, dc1, dc2;

  int total = 0;
  int bad   = 0;

  ent_t        mq [3][$];
  logic [7:0]  mseq [3];
  int          mdrop [3];
  int          depth_of [3] = '{4, 4, 8};
  bit          pol [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  sample_frame_fifo #(.DATA_W(22), .NUM_CH(2), .DEPTH(4),
                      .DROP_OLDEST(pulseox_pkg::DROP_NEWEST), .SEQ_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .new_samples(new_samples),
    .samples_in(samples[43:0]), .frame_valid(fv0), .frame_data(fd0),
    .frame_seq(fs0), .frame_ready(frame_ready), .level(lv0), .full(fu0),
    .empty(em0), .drop_cnt(dc0));

  sample_frame_fifo #(.DATA_W(22), .NUM_CH(2), .DEPTH(4),
                      .DROP_OLDEST(pulseox_pkg::DROP_OLDEST), .SEQ_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .new_samples(new_samples),
    .samples_in(samples[43:0]), .frame_valid(fv1), .frame_data(fd1),
    .frame_seq(fs1), .frame_ready(frame_ready), .level(lv1), .full(fu1),
    .empty(em1), .drop_cnt(dc1));

  sample_frame_fifo #(.DATA_W(22), .NUM_CH(4), .DEPTH(8),
                      .DROP_OLDEST(pulseox_pkg::DROP_NEWEST), .SEQ_W(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .new_samples(new_samples),
    .samples_in(samples), .frame_valid(fv2), .frame_data(fd2),
    .frame_seq(fs2), .frame_ready(frame_ready), .level(lv2), .full(fu2),
    .empty(em2), .drop_cnt(dc2));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic fetch(input int i, output logic v, output logic [87:0] d,
                       output logic [7:0] s, output int lvl, output logic f,
                       output logic e, output logic [15:0] dcn);
    case (i)
      0:       begin v = fv0; d = 88'(fd0); s = fs0; lvl = int'(lv0); f = fu0; e = em0; dcn = dc0; end
      1:       begin v = fv1; d = 88'(fd1); s = fs1; lvl = int'(lv1); f = fu1; e = em1; dcn = dc1; end
      default: begin v = fv2; d = fd2;      s = fs2; lvl = int'(lv2); f = fu2; e = em2; dcn = dc2; end
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mseq[i]  = '0;
      mdrop[i] = 0;
    end
  endtask

  // One clock edge of behaviour: a read consumes the head seen before the
  // edge, then the strobe either queues, displaces the oldest, or is lost.
  task automatic model_step(input bit wr, input bit rdy, input bit clr, input logic [87:0] d);
    ent_t e;
    if (!reset_n || clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (rdy && mq[i].size() > 0) void'(mq[i].pop_front());
      if (wr) begin
        e.d = (i == 2) ? d : (d & 88'hFFF_FFFF_FFFF);
        e.s = mseq[i];
        if (mq[i].size() < depth_of[i]) begin
          mq[i].push_back(e);
        end else begin
          if (pol[i]) begin
            void'(mq[i].pop_front());
            mq[i].push_back(e);
          end
          if (mdrop[i] < 65535) mdrop[i]++;
        end
        mseq[i] = mseq[i] + 8'd1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic        v, f, e;
    logic [87:0] d;
    logic [7:0]  s;
    logic [15:0] dcn;
    int          lvl, n;
    for (int i = 0; i < 3; i++) begin
      fetch(i, v, d, s, lvl, f, e, dcn);
      n = mq[i].size();
      chk($sformatf("%s.u%0d.valid", ph, i), 128'(v), 128'(n > 0));
      chk($sformatf("%s.u%0d.data", ph, i), 128'(d), 128'((n > 0) ? mq[i][0].d : 88'd0));
      chk($sformatf("%s.u%0d.seq", ph, i), 128'(s), 128'((n > 0) ? mq[i][0].s : 8'd0));
      chk($sformatf("%s.u%0d.level", ph, i), 128'(lvl), 128'(n));
      chk($sformatf("%s.u%0d.full", ph, i), 128'(f), 128'(n == depth_of[i]));
      chk($sformatf("%s.u%0d.empty", ph, i), 128'(e), 128'(n == 0));
      chk($sformatf("%s.u%0d.drop", ph, i), 128'(dcn), 128'(mdrop[i]));
    end
  endtask

  task automatic cycle(input bit wr, input bit rdy, input bit clr,
                       input logic [87:0] d, input bit do_chk, input string ph);
    new_samples = wr;
    frame_ready = rdy;
    clear       = clr;
    samples     = d;
    @(posedge clk);
    model_step(wr, rdy, clr, d);
    #1;
    if (do_chk) check_all(ph);
  endtask

  function automatic logic [87:0] mk(input int a, input int b);
    return (88'(b) << 22) | 88'(a);
  endfunction

  function automatic logic [87:0] rnd88();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[87:0];
  endfunction

  initial begin
    logic [87:0] d;
    int          rp;
    model_reset();
    #1 reset_n = 1'b0;
    #1 check_all("rst");
    cycle(0, 0, 0, '0, 1, "rst_hold");
    cycle(0, 0, 0, '0, 1, "rst_hold");
    reset_n = 1'b1;

    // Basic ordering with consumer stalled, then drained.
    cycle(1, 0, 0, mk(1, 2), 1, "basic");
    cycle(1, 0, 0, mk(3, 4), 1, "basic");
    cycle(1, 0, 0, mk(5, 5), 1, "basic");
    chk("basic.level3", 128'(lv0), 128'(3));
    chk("basic.head_seq0", 128'(fs0), 128'(0));
    for (int k = 0; k < 4; k++) begin
      if (fv0)
        $display("read seq=%0d ch0=%0d ch1=%0d", fs0,
                 channel_slice(256'(fd0), 22, 0), channel_slice(256'(fd0), 22, 1));
      cycle(0, 1, 0, '0, 1, "basic_rd");
    end
    chk("basic.empty", 128'(em0), 128'(1));

    // Overflow: six strobes with no reads, then drain.
    for (int k = 0; k < 6; k++) cycle(1, 0, 0, rnd88(), 1, "ovf");
    chk("ovf.full0", 128'(fu0), 128'(1));
    chk("ovf.drop0", 128'(dc0), 128'(2));
    chk("ovf.drop1", 128'(dc1), 128'(2));
    chk("ovf.head1_seq", 128'(fs1), 128'(5));
    for (int k = 0; k < 9; k++) cycle(0, 1, 0, '0, 1, "ovf_rd");

    // Simultaneous write/read at FULL, then at EMPTY.
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, rnd88(), 1, "fill");
    cycle(1, 1, 0, rnd88(), 1, "full_wr_rd");
    chk("full_wr_rd.level", 128'(lv0), 128'(4));
    for (int k = 0; k < 9; k++) cycle(0, 1, 0, '0, 1, "drain");
    cycle(1, 1, 0, rnd88(), 1, "empty_wr_rd");
    chk("empty_wr_rd.level", 128'(lv0), 128'(1));

    // Clear wins over a same-cycle strobe.
    cycle(1, 0, 0, rnd88(), 1, "pre_clr");
    cycle(1, 0, 0, rnd88(), 1, "pre_clr");
    cycle(1, 1, 1, rnd88(), 1, "clr");
    chk("clr.level", 128'(lv0), 128'(0));
    cycle(1, 0, 0, rnd88(), 1, "post_clr");
    chk("post_clr.seq0", 128'(fs0), 128'(0));

    // Randomised traffic with alternating consumer pressure.
    for (int k = 0; k < 2000; k++) begin
      rp = ((k / 200) % 2 == 1) ? 20 : 80;
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < rp,
            $urandom_range(0, 99) < 2, rnd88(), 1, "rand");
    end

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, rnd88(), 1, "burst");
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all("arst");
    cycle(1, 1, 0, rnd88(), 1, "arst_hold");
    reset_n = 1'b1;
    cycle(1, 0, 0, rnd88(), 1, "post_arst");
    chk("post_arst.seq0", 128'(fs2), 128'(0));

    // Sequence wrap past 255 with a consumer keeping pace.
    cycle(0, 0, 1, '0, 1, "wrap_clr");
    for (int k = 0; k < 262; k++) cycle(1, 1, 0, rnd88(), 1, "wrap");

    // Drop counter saturation under continuous overflow.
    cycle(0, 0, 1, '0, 1, "sat_clr");
    for (int k = 0; k < 65545; k++) begin
      d = rnd88();
      cycle(1, 0, 0, d, (k % 4096) == 0, "sat");
    end
    check_all("sat_end");
    chk("sat.drop2", 128'(dc2), 128'(16'hFFFF));
    chk("sat.drop1", 128'(dc1), 128'(16'hFFFF));
    for (int k = 0; k < 10; k++) cycle(0, 1, 0, '0, 1, "sat_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
